// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, the 9-bit MMIO
// bus layout and default timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [31:0] UART_MMIO_ADDR     = 32'h0000_fff0;
    localparam int          UART_BUS_W         = 9;
    localparam int          UART_STROBE_BIT    = 8;
    localparam int          UART_BYTE_W        = 8;
    localparam int          UART_FRAME_BITS    = 10;
    localparam int          DEFAULT_BAUD_DIV   = 868;
    localparam int          DEFAULT_FIFO_DEPTH = 16;

    // Core-side bus: strobe in bit 8, payload byte in bits 7:0.
    typedef struct packed {
        logic                   strobe;
        logic [UART_BYTE_W-1:0] data;
    } uart_bus_t;

    function automatic uart_bus_t unpack_uart_bus(input logic [UART_BUS_W-1:0] bus);
        return uart_bus_t'(bus);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with show-ahead read data; a push while full is accepted
// only when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == LW'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Buffered 8N1 UART transmitter: bytes from the core's MMIO strobe are queued
// in a FIFO and serialised LSB first at a fixed baud divisor.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [UART_BUS_W-1:0]         uart_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int              CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD_DIV - 1);

    uart_bus_t              bus;
    logic                   push_req;
    logic                   pop_en;
    logic [UART_BYTE_W-1:0] fifo_data;
    logic                   fifo_full;
    logic                   fifo_empty;

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [UART_BYTE_W-1:0] shift_q, shift_d;
    logic [2:0]             idx_q, idx_d;
    logic                   tx_q, tx_d;
    logic                   overflow_q, overflow_d;
    logic                   expire;

    assign bus      = unpack_uart_bus(uart_in);
    assign push_req = bus.strobe;
    assign expire   = (cnt_q == '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data (bus.data),
        .pop       (pop_en),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Frame sequencer; a STOP expiry with data waiting chains straight into
    // the next START so back-to-back frames have no idle gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        pop_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_en  = 1'b1;
                    shift_d = fifo_data;
                    tx_d    = 1'b0;
                    cnt_d   = BAUD_LOAD;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (expire) begin
                    tx_d    = shift_q[0];
                    idx_d   = 3'd0;
                    cnt_d   = BAUD_LOAD;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DATA: begin
                if (expire) begin
                    cnt_d = BAUD_LOAD;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_STOP: begin
                if (expire) begin
                    if (!fifo_empty) begin
                        pop_en  = 1'b1;
                        shift_d = fifo_data;
                        tx_d    = 1'b0;
                        cnt_d   = BAUD_LOAD;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A dropped byte is one pushed while full with no pop freeing a slot.
    always_comb begin
        overflow_d = overflow_q | (push_req & fifo_full & ~pop_en);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) | (level != '0);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench: a frame-level model (byte queue plus position within
// the current 10-bit frame) is compared against the DUT on every cycle.
module tb_uart_tx_ctrl;

    localparam int B  = 4;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic [8:0]    uart_in = '0;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] level;

    int n_checks = 0;
    int n_fails  = 0;

    uart_tx_ctrl #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (D)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .uart_in  (uart_in),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clock = ~clock;

    // Model: the line shows frame bit (m_pos / B) of m_byte while a frame is active.
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = '0;
    bit         m_ovf    = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            if (m_active) begin
                m_pos++;
                if (m_pos == 10 * B) m_active = 1'b0;
            end
            if (!m_active && m_q.size() != 0) begin
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (uart_in[8]) begin
                if (m_q.size() < D) m_q.push_back(uart_in[7:0]);
                else                m_ovf = 1'b1;
            end
        end
    end

    function automatic logic model_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / B;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_byte[3'(b - 1)];
    endfunction

    // Independent line decoder: samples mid-bit, records completed bytes.
    logic [7:0] dec_q[$];
    bit         d_on   = 1'b0;
    int         d_cnt  = 0;
    logic [7:0] d_byte = '0;

    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_on  = 1'b0;
            d_cnt = 0;
        end else if (!d_on) begin
            if (tx == 1'b0) begin
                d_on  = 1'b1;
                d_cnt = 0;
            end
        end else begin
            int idx;
            d_cnt++;
            if (d_cnt >= B + B / 2 && d_cnt < 9 * B && ((d_cnt - B / 2) % B) == 0) begin
                idx = (d_cnt - B / 2) / B - 1;
                d_byte[idx[2:0]] = tx;
            end
            if (d_cnt == 9 * B + B / 2) begin
                if (tx) dec_q.push_back(d_byte);
                d_on = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic compare_model();
        check_output("tx_vs_model", 32'(tx), 32'(model_tx()));
        check_output("busy_vs_model", 32'(busy), 32'(m_active || m_q.size() != 0));
        check_output("level_vs_model", 32'(level), 32'(m_q.size()));
        check_output("overflow_vs_model", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            compare_model();
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        uart_in = {1'b1, b};
        tick(1);
        uart_in = '0;
    endtask

    task automatic idle_literal(input int n);
        repeat (n) begin
            tick(1);
            check_output("idle_tx", 32'(tx), 32'd1);
            check_output("idle_busy", 32'(busy), 32'd0);
            check_output("idle_level", 32'(level), 32'd0);
            check_output("idle_overflow", 32'(overflow), 32'd0);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check_output("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [39:0] exp55;
        logic [7:0]  exp_bytes[6];
        int          lv[6];
        int          base;

        repeat (3) @(negedge clock);
        check_output("reset_tx", 32'(tx), 32'd1);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_level", 32'(level), 32'd0);
        check_output("reset_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;

        idle_literal(1000);

        // Single byte 0x55, pattern written out in time order.
        exp55 = 40'b0000_1111_0000_1111_0000_1111_0000_1111_0000_1111;
        base  = dec_q.size();
        apply_stimulus(8'h55);
        check_output("t1_level_push", 32'(level), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            check_output("t1_tx_pattern", 32'(tx), 32'(exp55[40 - k]));
            if (k == 1)  check_output("t1_level_pop", 32'(level), 32'd0);
            if (k == 40) check_output("t1_busy_stop", 32'(busy), 32'd1);
        end
        tick(1);
        check_output("t1_busy_fall", 32'(busy), 32'd0);
        tick(4);
        check_output("t1_dec_count", 32'(dec_q.size() - base), 32'd1);
        if (dec_q.size() > base) check_output("t1_dec_byte", 32'(dec_q[base]), 32'h55);

        // Three back-to-back frames.
        base = dec_q.size();
        uart_in = {1'b1, 8'hA5}; tick(1);
        uart_in = {1'b1, 8'h3C}; tick(1);
        check_output("t2_start1", 32'(tx), 32'd0);
        uart_in = {1'b1, 8'hFF}; tick(1);
        uart_in = '0;
        tick(38);
        check_output("t2_stop1", 32'(tx), 32'd1);
        tick(1);
        check_output("t2_start2", 32'(tx), 32'd0);
        tick(39);
        check_output("t2_stop2", 32'(tx), 32'd1);
        tick(1);
        check_output("t2_start3", 32'(tx), 32'd0);
        tick(39);
        check_output("t2_stop3", 32'(tx), 32'd1);
        check_output("t2_busy_stop3", 32'(busy), 32'd1);
        tick(1);
        check_output("t2_busy_fall", 32'(busy), 32'd0);
        tick(4);
        exp_bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00};
        check_output("t2_dec_count", 32'(dec_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++)
            if (dec_q.size() > base + i)
                check_output("t2_dec_byte", 32'(dec_q[base + i]), 32'(exp_bytes[i]));

        // Overflow: sixth byte into a depth-4 FIFO is dropped.
        base = dec_q.size();
        lv   = '{1, 1, 2, 3, 4, 4};
        for (int i = 0; i < 6; i++) begin
            uart_in = {1'b1, 8'(i + 1)};
            tick(1);
            check_output("t3_level_seq", 32'(level), 32'(lv[i]));
            if (i == 4) check_output("t3_ovf_before", 32'(overflow), 32'd0);
            if (i == 5) check_output("t3_ovf_after", 32'(overflow), 32'd1);
        end
        uart_in = '0;
        wait_idle(400);
        tick(4);
        check_output("t3_ovf_sticky", 32'(overflow), 32'd1);
        check_output("t3_dec_count", 32'(dec_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++)
            if (dec_q.size() > base + i)
                check_output("t3_dec_byte", 32'(dec_q[base + i]), 32'(i + 1));

        do_reset();
        tick(1);
        check_output("t4_ovf_cleared", 32'(overflow), 32'd0);

        // Push while full on the STOP-expiry pop edge is accepted.
        base = dec_q.size();
        for (int i = 0; i < 5; i++) begin
            uart_in = {1'b1, 8'(8'h10 + i)};
            tick(1);
        end
        uart_in = '0;
        check_output("t4_level_full", 32'(level), 32'd4);
        tick(36);
        check_output("t4_stop_tx", 32'(tx), 32'd1);
        check_output("t4_level_pre", 32'(level), 32'd4);
        uart_in = {1'b1, 8'h15};
        tick(1);
        uart_in = '0;
        check_output("t4_level_same", 32'(level), 32'd4);
        check_output("t4_ovf_clear", 32'(overflow), 32'd0);
        check_output("t4_next_start", 32'(tx), 32'd0);
        wait_idle(400);
        tick(4);
        check_output("t4_dec_count", 32'(dec_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++)
            if (dec_q.size() > base + i)
                check_output("t4_dec_byte", 32'(dec_q[base + i]), 32'(8'h10 + i));

        // Reset in the middle of data bit 3 of 0xC3 with two bytes queued.
        uart_in = {1'b1, 8'hC3}; tick(1);
        uart_in = {1'b1, 8'h11}; tick(1);
        uart_in = {1'b1, 8'h22}; tick(1);
        uart_in = '0;
        tick(16);
        check_output("t5_bit3_tx", 32'(tx), 32'd0);
        check_output("t5_level_q", 32'(level), 32'd2);
        check_output("t5_busy_q", 32'(busy), 32'd1);
        base = dec_q.size();
        #2 reset_n = 1'b0;
        #1;
        check_output("t5_rst_tx", 32'(tx), 32'd1);
        check_output("t5_rst_busy", 32'(busy), 32'd0);
        check_output("t5_rst_level", 32'(level), 32'd0);
        check_output("t5_rst_ovf", 32'(overflow), 32'd0);
        tick(2);
        reset_n = 1'b1;
        idle_literal(200);
        check_output("t5_no_frames", 32'(dec_q.size() - base), 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
